// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, byte width and default bit time for the UART TX arbiter
package uart_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP = 2'd3;
  localparam int CLKS_PER_BIT = 868;
  localparam int BYTE_W = 8;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin find-first-set starting at ptr, wrapping modulo N
module rr_select #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    index = sum >= (IW + 1)'(N) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
    valid = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_transmitter between NUM_REQ byte producers
// Optional watchdog on tx_done enabled by UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CLKS = CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 20000,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic                      o_busy,
  output logic                      o_tx_start,
  output logic [BYTE_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic [IW-1:0]             o_grant_id,
  output logic                      o_timeout
);
  localparam int CW = $clog2(max_int(max_int(GAP_CLKS, TIMEOUT_CLKS), 1) + 1);
  logic [1:0] state;
  logic [IW-1:0] rr_ptr, sel;
  logic sel_valid, wd_hit;
  logic [CW-1:0] cnt, cnt_sat;
  rr_select #(.N(NUM_REQ)) u_sel (
    .req  (i_req),
    .ptr  (rr_ptr),
    .valid(sel_valid),
    .index(sel)
  );
  assign o_busy = state != ST_IDLE;
  assign cnt_sat = &cnt ? cnt : cnt + 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign wd_hit = state == ST_WAIT_DONE && cnt == CW'(TIMEOUT_CLKS - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) o_timeout <= 1'b0;
    else if (wd_hit && !i_tx_done) o_timeout <= 1'b1;
`else
  assign wd_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif
  // tx_start is registered off START so it lands two cycles after a request is seen in IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      o_ack <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
      o_grant_id <= '0;
    end else begin
      o_ack <= '0;
      o_tx_start <= state == ST_START;
      case (state)
        ST_IDLE:
          if (sel_valid) begin
            o_grant_id <= sel;
            o_tx_data <= i_req_data[{sel, 3'b000} +: BYTE_W];
            state <= ST_START;
          end
        ST_START: begin
          cnt <= '0;
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE:
          if (i_tx_done || wd_hit) begin
            o_ack <= NUM_REQ'(1) << o_grant_id;
            rr_ptr <= o_grant_id == IW'(NUM_REQ - 1) ? '0 : o_grant_id + 1'b1;
            cnt <= '0;
            state <= GAP_CLKS > 0 ? ST_GAP : ST_IDLE;
          end else cnt <= cnt_sat;
        default:
          if (cnt == CW'(GAP_CLKS - 1)) state <= ST_IDLE;
          else cnt <= cnt_sat;
      endcase
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_transmitter between NUM_REQ byte producers (e.g. status reporter, echo path, debug dump). It latches the winning requester's byte, pulses tx_start to the transmitter, and waits for tx_done. It then acknowledges the winning requester and enforces a configurable idle gap before the next frame. It sits between the producers and the uart_transmitter in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CLKS, 868, idle clk cycles inserted after tx_done before the next grant (0 = no gap; 868 = one bit time at 100 MHz / 115200)
TIMEOUT_CLKS, 20000, watchdog limit in clk cycles from tx_start to tx_done (used only with the optional feature)

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
i_req  input  NUM_REQ  per-requester level request; hold until ack
i_req_data  input  8*NUM_REQ  byte of requester k on bits [8k+7:8k]
o_ack  output  NUM_REQ  one-cycle pulse to requester k when its byte has finished transmitting (tx_done seen)
o_busy  output  1  high whenever state != IDLE
o_tx_start  output  1  one-cycle start pulse to uart_transmitter
o_tx_data  output  8  byte to uart_transmitter; stable from the o_tx_start cycle until tx_done
i_tx_done  input  1  completion pulse from uart_transmitter
o_grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
o_timeout  output  1  sticky watchdog error (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ack=0, o_busy=0, o_tx_start=0, o_tx_data=0, o_grant_id=0, o_timeout=0, rr pointer=0, counters=0.
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If any i_req bit is set, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the winner's index into o_grant_id and its byte into o_tx_data; go to START.
  - Latency from i_req rising to o_tx_start is 2 cycles.
- START: o_tx_start=1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE:
  - On i_tx_done: pulse o_ack[o_grant_id] for 1 cycle and set rr_ptr = (o_grant_id+1) mod NUM_REQ.
  - Then go to GAP if GAP_CLKS>0, else to IDLE.
  - An i_tx_done pulse outside WAIT_DONE is ignored.
- GAP: count GAP_CLKS cycles, then go to IDLE. i_req is not sampled during GAP.
- Requester contract:
  - Keep i_req high and data stable until ack.
  - i_req is sampled only in IDLE, and the byte is latched at grant, so later data changes do not affect the frame in flight.
  - A requester dropping i_req after grant still gets its frame sent and acked.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Simultaneous i_tx_done with a new i_req: the ack is issued first. The new arbitration happens only after GAP/IDLE.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Width rule: the gap/timeout counter is $clog2(max(GAP_CLKS,TIMEOUT_CLKS)+1) bits wide and saturates; it never wraps.
- Reset mid-frame: everything returns to reset values and no ack is issued. The transmitter shares reset_n (inverted at the top level).

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_DONE counts cycles from entry.
  - Reaching TIMEOUT_CLKS without i_tx_done sets o_timeout=1 (sticky until reset) and pulses o_ack[o_grant_id].
  - The arbiter then advances rr_ptr and goes to GAP, so one dead transmitter cannot lock up producers.
- Undefined: no watchdog counter; WAIT_DONE waits indefinitely; o_timeout is tied 0.

Decomposition:
- Package uart_pkg: state encoding constants (ST_IDLE=0, ST_START=1, ST_WAIT_DONE=2, ST_GAP=3), default CLKS_PER_BIT=868, BYTE_W=8.
- One sub-module, rr_select: combinational round-robin find-first-set from pointer, with outputs valid and index.
- The FSM, counter and data latch stay in uart_tx_arbiter.

Test Plan:
- Single request: i_req=4'b0001, data0=8'h75, loopback through uart_transmitter and uart_receiver (clks_per_bit 868).
  - o_tx_start appears 2 cycles after i_req.
  - Receiver o_data_byte=8'h75.
  - o_ack[0] pulses once after tx_done.
  - o_busy stays high through the GAP.
- All four requesting continuously with data 8'hA0..8'hA3: receiver sees A0,A1,A2,A3,A0; grant order 0,1,2,3,0.
- Pointer wrap: after grant 3, assert only i_req[1] and i_req[3] → grant 1, then grant 3.
- Data change after grant: change data2 from 8'h55 to 8'hAA one cycle after grant → 8'h55 is received.
- Reset mid-frame: deassert reset_n during WAIT_DONE.
  - All outputs return to 0 immediately and no ack is issued.
  - After release, a pending request is re-arbitrated from index 0.
- With UART_TX_ARB_TIMEOUT_EN and i_tx_done forced 0:
  - o_timeout rises TIMEOUT_CLKS cycles after o_tx_start.
  - o_ack pulses and the next requester is granted.
